// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID checker: state encoding,
// slave word addresses and counter widths.
package sysid_check_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned TMO_CNT_W = 16;
    localparam int unsigned LAT_CNT_W = 3;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_ID  = 3'd1,
        LAT_ID = 3'd2,
        RD_TS  = 3'd3,
        LAT_TS = 3'd4,
        DONE   = 3'd5
    } state_e;

endpackage

// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the system-ID and timestamp words,
// compares them with build-time constants and reports match/timeout status.
module sysid_checker
    import sysid_check_pkg::*;
#(
    parameter logic [WORD_W-1:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [WORD_W-1:0] EXPECTED_TS    = 32'd1575538621,
    parameter int unsigned       READ_LATENCY   = 0,
    parameter int unsigned       TIMEOUT_CYCLES = 255,
    parameter bit                AUTO_START     = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic              avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [WORD_W-1:0] avm_readdata,
    output logic [WORD_W-1:0] id_value,
    output logic [WORD_W-1:0] ts_value,
    output logic              busy,
    output logic              done,
    output logic              id_match,
    output logic              ts_match,
    output logic              timeout
);

    localparam bit                   ZERO_LAT  = (READ_LATENCY == 0);
    localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [LAT_CNT_W-1:0] LAT_LAST  = LAT_CNT_W'(READ_LATENCY - 1);

    state_e               state_q, state_d;
    logic                 pending_q, pending_d;
    logic                 rd_q, rd_d;
    logic                 addr_q, addr_d;
    logic [WORD_W-1:0]    id_q, id_d;
    logic [WORD_W-1:0]    ts_q, ts_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 id_match_q, id_match_d;
    logic                 ts_match_q, ts_match_d;
    logic                 timeout_q, timeout_d;
    logic [TMO_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [TMO_CNT_W-1:0] wait_cnt_inc;
    logic                 launch;
    logic                 cap_id;
    logic                 cap_ts;

    // State and result registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pending_q  <= AUTO_START;
            rd_q       <= 1'b0;
            addr_q     <= ADDR_ID;
            id_q       <= '0;
            ts_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            id_match_q <= 1'b0;
            ts_match_q <= 1'b0;
            timeout_q  <= 1'b0;
            wait_cnt_q <= '0;
            lat_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            id_q       <= id_d;
            ts_q       <= ts_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            id_match_q <= id_match_d;
            ts_match_q <= ts_match_d;
            timeout_q  <= timeout_d;
            wait_cnt_q <= wait_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
        end
    end

    assign wait_cnt_inc = wait_cnt_q + TMO_CNT_W'(1);

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        id_d       = id_q;
        ts_d       = ts_q;
        busy_d     = busy_q;
        done_d     = done_q;
        id_match_d = id_match_q;
        ts_match_d = ts_match_q;
        timeout_d  = timeout_q;
        wait_cnt_d = wait_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        launch     = 1'b0;
        cap_id     = 1'b0;
        cap_ts     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pending_q || start) begin
                    launch    = 1'b1;
                    pending_d = 1'b0;
                end
            end
            RD_ID, RD_TS: begin
                if (!avm_waitrequest) begin
                    if (ZERO_LAT) begin
                        cap_id = (state_q == RD_ID);
                        cap_ts = (state_q == RD_TS);
                    end else begin
                        rd_d      = 1'b0;
                        lat_cnt_d = '0;
                        state_d   = (state_q == RD_ID) ? LAT_ID : LAT_TS;
                    end
                end else if (wait_cnt_inc == TMO_LIMIT) begin
                    rd_d      = 1'b0;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = DONE;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                end
            end
            LAT_ID, LAT_TS: begin
                if (lat_cnt_q == LAT_LAST) begin
                    cap_id = (state_q == LAT_ID);
                    cap_ts = (state_q == LAT_TS);
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_CNT_W'(1);
                end
            end
            DONE: begin
                if (start) begin
                    launch     = 1'b1;
                    done_d     = 1'b0;
                    timeout_d  = 1'b0;
                    id_match_d = 1'b0;
                    ts_match_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            state_d    = RD_ID;
            rd_d       = 1'b1;
            addr_d     = ADDR_ID;
            busy_d     = 1'b1;
            wait_cnt_d = '0;
        end

        // ID captured: launch the timestamp read back-to-back
        if (cap_id) begin
            id_d       = avm_readdata;
            id_match_d = (avm_readdata == EXPECTED_ID);
            state_d    = RD_TS;
            rd_d       = 1'b1;
            addr_d     = ADDR_TS;
            wait_cnt_d = '0;
        end

        if (cap_ts) begin
            ts_d       = avm_readdata;
            ts_match_d = (avm_readdata == EXPECTED_TS);
            state_d    = DONE;
            rd_d       = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
        end
    end

    assign avm_read    = rd_q;
    assign avm_address = addr_q;
    assign id_value    = id_q;
    assign ts_value    = ts_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign id_match    = id_match_q;
    assign ts_match    = ts_match_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: two instances (zero-latency auto-start, and
// latency-2 / short-timeout manual-start) against a sequence-level model.
module tb_sysid_checker;

    localparam logic [31:0] D0_EXP_ID = 32'h0000_0000;
    localparam logic [31:0] D0_EXP_TS = 32'd1575538621;
    localparam logic [31:0] D1_EXP_ID = 32'hCAFE_0001;
    localparam logic [31:0] D1_EXP_TS = 32'h1234_5678;
    localparam int          STUCK     = 1000;

    logic              clock;
    logic              reset_n;
    logic [1:0]        start_s;
    logic [1:0]        wr_s;
    logic [1:0][31:0]  rdat_s;
    wire  [1:0]        addr_s;
    wire  [1:0]        rd_s;
    wire  [1:0][31:0]  idv_s;
    wire  [1:0][31:0]  tsv_s;
    wire  [1:0]        busy_s;
    wire  [1:0]        done_s;
    wire  [1:0]        idm_s;
    wire  [1:0]        tsm_s;
    wire  [1:0]        to_s;

    int          lat_p[2]  = '{0, 2};
    int          tmo_p[2]  = '{255, 4};
    logic [31:0] exp_idc[2];
    logic [31:0] exp_tsc[2];

    logic [31:0] words[2][2];
    int          hold[2][2];
    int          acc_n[2];
    int          hcnt[2];
    int          lat_left[2];
    logic        lat_addr[2];
    bit          prev_hold[2];
    logic [31:0] exp_id[2];
    logic [31:0] exp_ts[2];

    int n_checks = 0;
    int n_errors = 0;

    sysid_checker #(
        .EXPECTED_ID   (D0_EXP_ID),
        .EXPECTED_TS   (D0_EXP_TS),
        .READ_LATENCY  (0),
        .TIMEOUT_CYCLES(255),
        .AUTO_START    (1'b1)
    ) dut0 (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start_s[0]),
        .avm_address    (addr_s[0]),
        .avm_read       (rd_s[0]),
        .avm_waitrequest(wr_s[0]),
        .avm_readdata   (rdat_s[0]),
        .id_value       (idv_s[0]),
        .ts_value       (tsv_s[0]),
        .busy           (busy_s[0]),
        .done           (done_s[0]),
        .id_match       (idm_s[0]),
        .ts_match       (tsm_s[0]),
        .timeout        (to_s[0])
    );

    sysid_checker #(
        .EXPECTED_ID   (D1_EXP_ID),
        .EXPECTED_TS   (D1_EXP_TS),
        .READ_LATENCY  (2),
        .TIMEOUT_CYCLES(4),
        .AUTO_START    (1'b0)
    ) dut1 (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start_s[1]),
        .avm_address    (addr_s[1]),
        .avm_read       (rd_s[1]),
        .avm_waitrequest(wr_s[1]),
        .avm_readdata   (rdat_s[1]),
        .id_value       (idv_s[1]),
        .ts_value       (tsv_s[1]),
        .busy           (busy_s[1]),
        .done           (done_s[1]),
        .id_match       (idm_s[1]),
        .ts_match       (tsm_s[1]),
        .timeout        (to_s[1])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural slave: programmable hold-off per word, fixed read latency,
    // junk on readdata whenever the word is not due.
    initial begin : slave
        logic [31:0] rdat_v;
        bit          acc;
        wr_s   = '0;
        rdat_s = '0;
        for (int g = 0; g < 2; g++) begin
            acc_n[g] = 0; hcnt[g] = 0; lat_left[g] = 0; lat_addr[g] = 1'b0; prev_hold[g] = 1'b0;
        end
        forever begin
            @(negedge clock);
            for (int g = 0; g < 2; g++) begin
                acc    = 1'b0;
                rdat_v = $urandom;
                if (!reset_n) begin
                    wr_s[g] = 1'b0; hcnt[g] = 0; lat_left[g] = 0; acc_n[g] = 0; prev_hold[g] = 1'b0;
                end else begin
                    if (prev_hold[g])
                        check_eq($sformatf("d%0d_hold_read", g), 32'(rd_s[g] | to_s[g]), 32'd1);
                    if (rd_s[g])
                        check_eq($sformatf("d%0d_rd_addr", g), 32'(addr_s[g]), 32'(acc_n[g]));
                    if (lat_left[g] > 0) begin
                        lat_left[g]--;
                        if (lat_left[g] == 0) rdat_v = words[g][lat_addr[g]];
                    end
                    if (!rd_s[g]) begin
                        wr_s[g] = 1'b0; hcnt[g] = 0;
                    end else if (hcnt[g] < hold[g][addr_s[g]]) begin
                        wr_s[g] = 1'b1; hcnt[g]++;
                    end else begin
                        wr_s[g] = 1'b0; hcnt[g] = 0; acc = 1'b1;
                    end
                    prev_hold[g] = rd_s[g] && wr_s[g];
                    if (acc) begin
                        if (lat_p[g] == 0) rdat_v = words[g][addr_s[g]];
                        else begin
                            lat_left[g] = lat_p[g];
                            lat_addr[g] = addr_s[g];
                        end
                        acc_n[g]++;
                    end
                end
                rdat_s[g] = rdat_v;
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        for (int g = 0; g < 2; g++) begin
            check_eq($sformatf("%s_d%0d_read", tag, g), 32'(rd_s[g]), 32'd0);
            check_eq($sformatf("%s_d%0d_addr", tag, g), 32'(addr_s[g]), 32'd0);
            check_eq($sformatf("%s_d%0d_idv", tag, g), idv_s[g], 32'd0);
            check_eq($sformatf("%s_d%0d_tsv", tag, g), tsv_s[g], 32'd0);
            check_eq($sformatf("%s_d%0d_busy", tag, g), 32'(busy_s[g]), 32'd0);
            check_eq($sformatf("%s_d%0d_done", tag, g), 32'(done_s[g]), 32'd0);
            check_eq($sformatf("%s_d%0d_idm", tag, g), 32'(idm_s[g]), 32'd0);
            check_eq($sformatf("%s_d%0d_tsm", tag, g), 32'(tsm_s[g]), 32'd0);
            check_eq($sformatf("%s_d%0d_tmo", tag, g), 32'(to_s[g]), 32'd0);
        end
    endtask

    // One check sequence on instance g, triggered by start or by reset release.
    task automatic run_seq(input int g, input bit via_reset, input logic [31:0] idw,
                           input logic [31:0] tsw, input int h0, input int h1, input bit pulse);
        int t_exp, nacc, cyc;
        bit to_exp;
        words[g][0] = idw; words[g][1] = tsw;
        hold[g][0]  = h0;  hold[g][1]  = h1;
        t_exp = 0; nacc = 0; to_exp = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (!to_exp) begin
                if (hold[g][k] >= tmo_p[g]) begin
                    t_exp += tmo_p[g];
                    to_exp = 1'b1;
                end else begin
                    t_exp += hold[g][k] + 1 + lat_p[g];
                    nacc++;
                end
            end
        end
        if (nacc >= 1) exp_id[g] = idw;
        if (nacc == 2) exp_ts[g] = tsw;
        if (!via_reset) acc_n[g] = 0;
        @(negedge clock);
        if (via_reset) reset_n = 1'b1;
        else start_s[g] = 1'b1;
        @(negedge clock);
        start_s[g] = 1'b0;
        cyc = 0;
        check_eq($sformatf("d%0d_busy_start", g), 32'(busy_s[g]), 32'd1);
        check_eq($sformatf("d%0d_done_clear", g), 32'(done_s[g]), 32'd0);
        while (!done_s[g] && cyc < 200) begin
            @(negedge clock);
            cyc++;
            start_s[g] = (pulse && cyc == 1);
        end
        start_s[g] = 1'b0;
        check_eq($sformatf("d%0d_done_time", g), 32'(cyc), 32'(t_exp));
        check_eq($sformatf("d%0d_idv", g), idv_s[g], exp_id[g]);
        check_eq($sformatf("d%0d_tsv", g), tsv_s[g], exp_ts[g]);
        check_eq($sformatf("d%0d_idm", g), 32'(idm_s[g]), 32'(nacc >= 1 && idw == exp_idc[g]));
        check_eq($sformatf("d%0d_tsm", g), 32'(tsm_s[g]), 32'(nacc == 2 && tsw == exp_tsc[g]));
        check_eq($sformatf("d%0d_tmo", g), 32'(to_s[g]), 32'(to_exp));
        check_eq($sformatf("d%0d_busy_end", g), 32'(busy_s[g]), 32'd0);
        check_eq($sformatf("d%0d_read_end", g), 32'(rd_s[g]), 32'd0);
        check_eq($sformatf("d%0d_nreads", g), 32'(acc_n[g]), 32'(nacc));
        repeat (3) @(negedge clock);
        check_eq($sformatf("d%0d_done_held", g), 32'(done_s[g]), 32'd1);
        check_eq($sformatf("d%0d_no_rerun", g), 32'(busy_s[g]), 32'd0);
    endtask

    task automatic check_d1_idle(input string tag);
        check_eq({tag, "_d1_read"}, 32'(rd_s[1]), 32'd0);
        check_eq({tag, "_d1_busy"}, 32'(busy_s[1]), 32'd0);
        check_eq({tag, "_d1_nreads"}, 32'(acc_n[1]), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] idw, tsw;
        int g;
        exp_idc[0] = D0_EXP_ID; exp_idc[1] = D1_EXP_ID;
        exp_tsc[0] = D0_EXP_TS; exp_tsc[1] = D1_EXP_TS;
        for (int k = 0; k < 2; k++) begin
            exp_id[k] = '0; exp_ts[k] = '0;
            words[k][0] = '0; words[k][1] = '0; hold[k][0] = 0; hold[k][1] = 0;
        end
        reset_n = 1'b0;
        start_s = '0;
        repeat (2) @(negedge clock);
        check_reset_vals("reset");

        // Auto-start after reset on dut0; dut1 must stay idle
        run_seq(0, 1'b1, D0_EXP_ID, D0_EXP_TS, 0, 0, 1'b0);
        check_d1_idle("auto");
        run_seq(0, 1'b0, D0_EXP_ID, 32'h5DE7_0000, 0, 0, 1'b0);
        run_seq(0, 1'b0, D0_EXP_ID, D0_EXP_TS, 3, 3, 1'b0);
        run_seq(1, 1'b0, D1_EXP_ID, D1_EXP_TS, STUCK, STUCK, 1'b1);
        run_seq(1, 1'b0, D1_EXP_ID, D1_EXP_TS, 0, 0, 1'b1);
        run_seq(1, 1'b0, D1_EXP_ID, 32'h0BAD_0000, 1, STUCK, 1'b1);

        for (int i = 0; i < 24; i++) begin
            g   = int'($urandom_range(0, 1));
            idw = ($urandom_range(0, 1) != 0) ? exp_idc[g] : $urandom;
            tsw = ($urandom_range(0, 1) != 0) ? exp_tsc[g] : $urandom;
            run_seq(g, 1'b0, idw, tsw, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), g == 1);
        end

        // Reset in the middle of the timestamp read
        words[0][0] = D0_EXP_ID; words[0][1] = D0_EXP_TS;
        hold[0][0] = 0; hold[0][1] = 6;
        acc_n[0] = 0;
        @(negedge clock); start_s[0] = 1'b1;
        @(negedge clock); start_s[0] = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("mid_rd_ts_read", 32'(rd_s[0]), 32'd1);
        check_eq("mid_rd_ts_addr", 32'(addr_s[0]), 32'd1);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("async");
        for (int k = 0; k < 2; k++) begin
            exp_id[k] = '0; exp_ts[k] = '0;
        end
        run_seq(0, 1'b1, D0_EXP_ID, D0_EXP_TS, 2, 1, 1'b0);
        check_d1_idle("rerun");
        run_seq(1, 1'b0, 32'h1111_2222, D1_EXP_TS, 0, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
